// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the multicycle calculator:
//   op_t    - 4-bit opcode encoding carried on Ctrl
//   state_t - sequencer states. S_MUL is only used when CALC_MUL_EN is defined.
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_NOT  = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_SRA  = 4'h9,
        OP_ROL  = 4'hA,
        OP_ROR  = 4'hB,
        OP_EQ   = 4'hC,
        OP_MUL  = 4'hD,
        OP_SLT  = 4'hE,
        OP_RSVD = 4'hF
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/calc_regfile.sv
// -----------------------------------------------------------------------------
// calc_regfile
// NREG x DATA_W register file. Register 0 is hardwired to zero.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (clears all registers)
//   i_raddr_a/o_rdata_a   async read port A (X operand)
//   i_raddr_b/o_rdata_b   async read port B (Y operand)
//   i_dbg_addr/o_dbg_data async debug read port
//   i_we, i_waddr, i_wdata synchronous write port; writes to address 0 dropped
// -----------------------------------------------------------------------------
module calc_regfile #(
    parameter  int DATA_W = 8,
    parameter  int NREG   = 8,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Address 0 is forced to zero on read so R0 stays zero regardless of storage.
    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/multicycle_calculator.sv
// -----------------------------------------------------------------------------
// multicycle_calculator
// Register-file ALU. Single-cycle ops complete one cycle after accept; with
// CALC_MUL_EN defined, opcode D runs an unsigned shift-add multiply over
// DATA_W cycles. Without CALC_MUL_EN, opcode D behaves as reserved
// (result 0) and InReady is tied high.
// Ports:
//   Clk, Rst_n              clock, async active-low reset
//   InValid/InReady         command handshake (accept when both high)
//   Ctrl, Sel, DataIn       opcode, X source select (0 DataIn, 1 reg[RX]), data
//   RX, RY, RW, WEN         operand/destination registers, write enable
//   OutValid                one-cycle completion pulse
//   Result, Carry, Zero     held until next completion
//   DbgAddr/DbgData         combinational register read
// Config macro: CALC_MUL_EN
// -----------------------------------------------------------------------------
module multicycle_calculator
    import calc_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NREG   = 8,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [3:0]        Ctrl,
    input  logic              Sel,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    input  logic [ADDR_W-1:0] RW,
    input  logic              WEN,
    output logic              OutValid,
    output logic [DATA_W-1:0] Result,
    output logic              Carry,
    output logic              Zero,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData
);

    localparam int SH_W = $clog2(DATA_W);

    // Single-cycle ALU; returns {carry, result}.
    function automatic logic [DATA_W:0] f_alu(input op_t op,
                                              input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
        logic signed [DATA_W:0] xs;
        logic signed [DATA_W:0] ys;
        logic        [DATA_W:0] res;
        xs  = {x[DATA_W-1], x};
        ys  = {y[DATA_W-1], y};
        res = '0;
        case (op)
            OP_ADD:  res = xs + ys;
            OP_SUB:  res = xs - ys;
            OP_AND:  res = {1'b0, x & y};
            OP_OR:   res = {1'b0, x | y};
            OP_NOT:  res = {1'b0, ~x};
            OP_XOR:  res = {1'b0, x ^ y};
            OP_NOR:  res = {1'b0, ~(x | y)};
            OP_SHL:  res = {1'b0, y << x[SH_W-1:0]};
            OP_SHR:  res = {1'b0, y >> x[SH_W-1:0]};
            OP_SRA:  res = {1'b0, x[DATA_W-1], x[DATA_W-1:1]};
            OP_ROL:  res = {1'b0, x[DATA_W-2:0], x[DATA_W-1]};
            OP_ROR:  res = {1'b0, x[0], x[DATA_W-1:1]};
            OP_EQ:   res = {{DATA_W{1'b0}}, (x == y)};
            OP_SLT:  res = {{DATA_W{1'b0}}, ($signed(x) < $signed(y))};
            default: res = '0;  // MUL handled by the sequencer, F reserved
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] w_rx_data;
    logic [DATA_W-1:0] w_ry_data;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W:0]   w_alu;
    logic [DATA_W:0]   w_res;
    logic              w_accept;
    logic              w_done;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    op_t               w_op;

    assign w_op     = op_t'(Ctrl);
    assign w_x      = Sel ? w_rx_data : DataIn;
    assign w_y      = w_ry_data;
    assign w_alu    = f_alu(w_op, w_x, w_y);
    assign w_accept = InValid && InReady;
    assign w_wdata  = w_res[DATA_W-1:0];

    calc_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .i_clk      (Clk),
        .i_rst_n    (Rst_n),
        .i_raddr_a  (RX),
        .o_rdata_a  (w_rx_data),
        .i_raddr_b  (RY),
        .o_rdata_b  (w_ry_data),
        .i_dbg_addr (DbgAddr),
        .o_dbg_data (DbgData),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata)
    );

`ifdef CALC_MUL_EN
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [ADDR_W-1:0]   r_rw;
    logic                r_wen;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_mul_start;
    logic                w_mul_last;

    assign w_mul_start = w_accept && (w_op == OP_MUL);
    assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    // Partial sum including the current multiplier bit; on the last step this
    // is the full product.
    assign w_prod      = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_mul_start)           r_cnt <= '0;
            else if (r_state == S_MUL) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        InReady      = 1'b0;
        case (r_state)
            S_IDLE: begin
                InReady = 1'b1;
                if (InValid && (w_op == OP_MUL)) w_next_state = S_MUL;
            end
            S_MUL: begin
                if (r_cnt == CNT_LAST) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Multiply datapath: no reset needed, every field is loaded at start and
    // an aborted run never reaches writeback.
    always_ff @(posedge Clk) begin
        if (w_mul_start) begin
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, w_x};
            r_mplier <= w_y;
            r_rw     <= RW;
            r_wen    <= WEN;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign w_done  = (w_accept && !w_mul_start) || w_mul_last;
    assign w_res   = w_mul_last ? {|w_prod[2*DATA_W-1:DATA_W], w_prod[DATA_W-1:0]} : w_alu;
    assign w_we    = w_mul_last ? r_wen : (w_accept && !w_mul_start && WEN);
    assign w_waddr = w_mul_last ? r_rw : RW;
`else
    assign InReady = 1'b1;
    assign w_done  = w_accept;
    assign w_res   = w_alu;
    assign w_we    = w_accept && WEN;
    assign w_waddr = RW;
`endif

    // Completion register: results and flags update on the same edge as writeback.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutValid <= 1'b0;
            Result   <= '0;
            Carry    <= 1'b0;
            Zero     <= 1'b1;
        end else begin
            OutValid <= w_done;
            if (w_done) begin
                Result <= w_res[DATA_W-1:0];
                Carry  <= w_res[DATA_W];
                Zero   <= (w_res[DATA_W-1:0] == '0);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_calculator.sv
// -----------------------------------------------------------------------------
// tb_multicycle_calculator
// Directed bench for multicycle_calculator (DATA_W=8, NREG=8). Multiply
// scenarios run when CALC_MUL_EN is defined; otherwise opcode D is checked
// as a reserved single-cycle op.
// -----------------------------------------------------------------------------
module tb_multicycle_calculator;

    localparam int DATA_W = 8;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;

    logic              Clk;
    logic              Rst_n;
    logic              InValid;
    logic              InReady;
    logic [3:0]        Ctrl;
    logic              Sel;
    logic [DATA_W-1:0] DataIn;
    logic [ADDR_W-1:0] RX;
    logic [ADDR_W-1:0] RY;
    logic [ADDR_W-1:0] RW;
    logic              WEN;
    logic              OutValid;
    logic [DATA_W-1:0] Result;
    logic              Carry;
    logic              Zero;
    logic [ADDR_W-1:0] DbgAddr;
    logic [DATA_W-1:0] DbgData;

    int checks = 0;
    int errors = 0;

    multicycle_calculator #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .Ctrl     (Ctrl),
        .Sel      (Sel),
        .DataIn   (DataIn),
        .RX       (RX),
        .RY       (RY),
        .RW       (RW),
        .WEN      (WEN),
        .OutValid (OutValid),
        .Result   (Result),
        .Carry    (Carry),
        .Zero     (Zero),
        .DbgAddr  (DbgAddr),
        .DbgData  (DbgData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dbg(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        DbgAddr = addr;
        #1;
        check(tag, DbgData, exp);
    endtask

    // Drive one command at the falling edge, hold through one rising edge,
    // leave the bench #1 after that edge with InValid dropped.
    task automatic cmd(input logic [3:0] c, input logic s, input logic [7:0] d,
                       input logic [2:0] rx, input logic [2:0] ry,
                       input logic [2:0] rw, input logic w);
        @(negedge Clk);
        Ctrl = c; Sel = s; DataIn = d; RX = rx; RY = ry; RW = rw; WEN = w;
        InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    // Called #1 after the accept edge; counts cycles (accept cycle+1 = 1)
    // until OutValid, recording any cycle where InReady was high meanwhile.
    task automatic wait_out(output int cyc, output int ready_seen);
        cyc = 1;
        ready_seen = 0;
        while (OutValid !== 1'b1 && cyc < 30) begin
            if (InReady !== 1'b0) ready_seen++;
            @(posedge Clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int rdy;
        Rst_n = 1'b0; InValid = 1'b0; Ctrl = '0; Sel = 1'b0; DataIn = '0;
        RX = '0; RY = '0; RW = '0; WEN = 1'b0; DbgAddr = '0;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_outvalid", OutValid, 0);
        check("rst_result",   Result,   0);
        check("rst_carry",    Carry,    0);
        check("rst_zero",     Zero,     1);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("rst_inready", InReady, 1);
        dbg("rst_r1", 3'd1, 8'h00);

        // ADD DataIn + R0 -> R1
        cmd(4'h0, 1'b0, 8'h05, 3'd0, 3'd0, 3'd1, 1'b1);
        check("add_outvalid", OutValid, 1);
        check("add_result",   Result,   8'h05);
        check("add_carry",    Carry,    0);
        check("add_zero",     Zero,     0);
        dbg("add_wb_r1", 3'd1, 8'h05);
        @(posedge Clk);
        #1;
        check("add_pulse_end", OutValid, 0);
        check("add_hold",      Result,   8'h05);

        // R1 = R2 = 0x80, then R1 + R2 overflows to 0 with carry
        cmd(4'h0, 1'b0, 8'h80, 3'd0, 3'd0, 3'd1, 1'b1);
        cmd(4'h0, 1'b0, 8'h80, 3'd0, 3'd0, 3'd2, 1'b1);
        cmd(4'h0, 1'b1, 8'h00, 3'd1, 3'd2, 3'd0, 1'b0);
        check("add80_result", Result, 8'h00);
        check("add80_carry",  Carry,  1);
        check("add80_zero",   Zero,   1);

        // Write to R0 dropped, result still produced
        cmd(4'h0, 1'b0, 8'h33, 3'd0, 3'd0, 3'd0, 1'b1);
        check("r0_outvalid", OutValid, 1);
        check("r0_result",   Result,   8'h33);
        dbg("r0_read", 3'd0, 8'h00);

        // R4 = 5
        cmd(4'h0, 1'b0, 8'h05, 3'd0, 3'd0, 3'd4, 1'b1);
        dbg("r4_load", 3'd4, 8'h05);

        // SUB 3 - 5 = -2 -> 0x1FE
        cmd(4'h1, 1'b0, 8'h03, 3'd0, 3'd4, 3'd0, 1'b0);
        check("sub_result", Result, 8'hFE);
        check("sub_carry",  Carry,  1);
        // SUB 0x05 - 0x80 (sign-extended 0x180) -> 0x085
        cmd(4'h1, 1'b0, 8'h05, 3'd0, 3'd1, 3'd0, 1'b0);
        check("sub2_result", Result, 8'h85);
        check("sub2_carry",  Carry,  0);

        // Logic / shift / compare ops against R4 = 5 and R1 = 0x80
        cmd(4'h5, 1'b0, 8'hF0, 3'd0, 3'd4, 3'd0, 1'b0);
        check("xor_result", Result, 8'hF5);
        cmd(4'h6, 1'b0, 8'h0F, 3'd0, 3'd4, 3'd0, 1'b0);
        check("nor_result", Result, 8'hF0);
        cmd(4'h7, 1'b0, 8'h0A, 3'd0, 3'd4, 3'd0, 1'b0);
        check("shl_result", Result, 8'h14);
        cmd(4'h8, 1'b0, 8'h01, 3'd0, 3'd1, 3'd0, 1'b0);
        check("shr_result", Result, 8'h40);
        cmd(4'h9, 1'b0, 8'h84, 3'd0, 3'd0, 3'd0, 1'b0);
        check("sra_result", Result, 8'hC2);
        cmd(4'hC, 1'b0, 8'h05, 3'd0, 3'd4, 3'd0, 1'b0);
        check("eq_result",  Result, 8'h01);
        cmd(4'hE, 1'b0, 8'h80, 3'd0, 3'd4, 3'd0, 1'b0);
        check("slt_neg_result", Result, 8'h01);
        cmd(4'hE, 1'b0, 8'h05, 3'd0, 3'd1, 3'd0, 1'b0);
        check("slt_pos_result", Result, 8'h00);
        check("slt_pos_zero",   Zero,   1);
        cmd(4'h2, 1'b0, 8'h0F, 3'd0, 3'd4, 3'd0, 1'b0);
        check("and_result", Result, 8'h05);
        cmd(4'hF, 1'b0, 8'h5A, 3'd0, 3'd4, 3'd0, 1'b0);
        check("rsvd_result", Result, 8'h00);
        check("rsvd_carry",  Carry,  0);

        // R1 = 0x0C
        cmd(4'h0, 1'b0, 8'h0C, 3'd0, 3'd0, 3'd1, 1'b1);

`ifdef CALC_MUL_EN
        // 0x0B * 0x0C = 0x84 -> R5
        cmd(4'hD, 1'b0, 8'h0B, 3'd0, 3'd1, 3'd5, 1'b1);
        check("mul_busy", InReady, 0);
        wait_out(cyc, rdy);
        check("mul_latency",     cyc,     9);
        check("mul_ready_low",   rdy,     0);
        check("mul_result",      Result,  8'h84);
        check("mul_carry",       Carry,   0);
        check("mul_ready_after", InReady, 1);
        dbg("mul_wb_r5", 3'd5, 8'h84);

        // R6 = 0x10; 0x10 * 0x10 = 0x100
        cmd(4'h0, 1'b0, 8'h10, 3'd0, 3'd0, 3'd6, 1'b1);
        cmd(4'hD, 1'b0, 8'h10, 3'd0, 3'd6, 3'd0, 1'b0);
        wait_out(cyc, rdy);
        check("mul16_latency", cyc,    9);
        check("mul16_result",  Result, 8'h00);
        check("mul16_carry",   Carry,  1);
        check("mul16_zero",    Zero,   1);

        // MUL 3 * R4(5) -> R3, with a dependent ADD held on InValid throughout
        cmd(4'hD, 1'b0, 8'h03, 3'd0, 3'd4, 3'd3, 1'b1);
        Ctrl = 4'h0; Sel = 1'b1; DataIn = 8'h00; RX = 3'd3; RY = 3'd4; RW = 3'd7; WEN = 1'b1;
        InValid = 1'b1;
        wait_out(cyc, rdy);
        check("chain_mul_latency", cyc,    9);
        check("chain_mul_result",  Result, 8'h0F);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("chain_add_valid",  OutValid, 1);
        check("chain_add_result", Result,   8'h14);
        dbg("chain_wb_r7", 3'd7, 8'h14);

        // Reset 4 cycles into a MUL targeting R3
        cmd(4'hD, 1'b0, 8'h02, 3'd0, 3'd4, 3'd3, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        check("abort_no_early_valid", OutValid, 0);
        dbg("abort_r3_before", 3'd3, 8'h0F);
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("abort_ready", InReady, 1);
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (OutValid !== 1'b0) rdy++;
        end
        check("abort_no_valid", rdy, 0);
        dbg("abort_r3_after", 3'd3, 8'h00);
`else
        // Without the multiplier, opcode D is a single-cycle reserved op
        cmd(4'hD, 1'b0, 8'h0B, 3'd0, 3'd1, 3'd5, 1'b1);
        check("d_outvalid", OutValid, 1);
        check("d_result",   Result,   8'h00);
        check("d_carry",    Carry,    0);
        check("d_zero",     Zero,     1);
        check("d_ready",    InReady,  1);
        dbg("d_wb_r5", 3'd5, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
